// File: rtl/csr_file_if.sv
// CSR request/response bundle between the writeback stage and csr_file.
// write_func: 0 none, 1 RW, 2 RS, 3 RC. input_select: 1 selects rs1_value, 0 selects imm_value.
interface csr_file_if;
  logic        csr_valid;
  logic        read_enable;
  logic        write_enable;
  logic [4:0]  imm_value;
  logic        input_select;
  logic [1:0]  write_func;
  logic [11:0] csr_addr;
  logic [31:0] rs1_value;
  logic        resp_valid;
  logic [31:0] rd_value;
  logic        illegal;

  modport master (
    output csr_valid, read_enable, write_enable, imm_value, input_select, write_func,
    output csr_addr, rs1_value,
    input  resp_valid, rd_value, illegal
  );

  modport slave (
    input  csr_valid, read_enable, write_enable, imm_value, input_select, write_func,
    input  csr_addr, rs1_value,
    output resp_valid, rd_value, illegal
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic read-modify-write, trap entry and mret state updates.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input  logic        clk,
  input  logic        rst,
  csr_file_if.slave   bus,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        instr_retire,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        global_ie
);

  localparam logic [1:0] FuncNone = 2'd0;
  localparam logic [1:0] FuncRw   = 2'd1;
  localparam logic [1:0] FuncRs   = 2'd2;
  localparam logic [1:0] FuncRc   = 2'd3;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rd_value_q, rd_value_d;
  logic        illegal_q, illegal_d;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  logic        hit;
  logic        legal;
  logic        accept;
  logic        do_write;
  logic [31:0] old_value;
  logic [31:0] src;
  logic [31:0] new_value;

  // Read mux; hit flags an implemented address.
  always_comb begin
    hit       = 1'b1;
    old_value = 32'd0;
    case (bus.csr_addr)
      12'h300: old_value = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      12'h301: old_value = MISA_VALUE;
      12'h304: old_value = mie_q;
      12'h305: old_value = {mtvec_q, 2'b00};
      12'h340: old_value = mscratch_q;
      12'h341: old_value = {mepc_q, 2'b00};
      12'h342: old_value = mcause_q;
      12'h343: old_value = mtval_q;
      12'hF11, 12'hF12, 12'hF13: old_value = 32'd0;
      12'hF14: old_value = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: old_value = mcycle_q[31:0];
      12'hB80, 12'hC80: old_value = mcycle_q[63:32];
      12'hB02, 12'hC02: old_value = minstret_q[31:0];
      12'hB82, 12'hC82: old_value = minstret_q[63:32];
`endif
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    accept   = bus.csr_valid & ~trap_valid & ~mret_valid;
    legal    = hit & ~(bus.write_enable & (bus.csr_addr[11:10] == 2'b11));
    do_write = accept & legal & bus.write_enable & (bus.write_func != FuncNone);
    src      = bus.input_select ? bus.rs1_value : {27'd0, bus.imm_value};
    case (bus.write_func)
      FuncRw:  new_value = src;
      FuncRs:  new_value = old_value | src;
      FuncRc:  new_value = old_value & ~src;
      default: new_value = old_value;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
    if (trap_valid) begin
      mepc_d         = trap_pc[31:2];
      mcause_d       = trap_cause;
      mtval_d        = trap_tval;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_valid) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (do_write) begin
      case (bus.csr_addr)
        12'h300: begin
          mstatus_mie_d  = new_value[3];
          mstatus_mpie_d = new_value[7];
        end
        12'h304: mie_d      = new_value;
        12'h305: mtvec_d    = new_value[31:2];
        12'h340: mscratch_d = new_value;
        12'h341: mepc_d     = new_value[31:2];
        12'h342: mcause_d   = new_value;
        12'h343: mtval_d    = new_value;
        default: ;
      endcase
    end
  end

  always_comb begin
    resp_valid_d = accept;
    illegal_d    = accept & ~legal;
    rd_value_d   = (accept & legal & bus.read_enable) ? old_value : 32'd0;
  end

`ifdef CSR_COUNTERS_EN
  // A write to one half replaces that cycle's increment; the other half holds.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, instr_retire};
    if (do_write) begin
      case (bus.csr_addr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], new_value};
        12'hB80: mcycle_d   = {new_value, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], new_value};
        12'hB82: minstret_d = {new_value, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= 30'd0;
      mscratch_q     <= 32'd0;
      mepc_q         <= 30'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
      resp_valid_q   <= 1'b0;
      rd_value_q     <= 32'd0;
      illegal_q      <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      resp_valid_q   <= resp_valid_d;
      rd_value_q     <= rd_value_d;
      illegal_q      <= illegal_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.rd_value   = rd_value_q;
  assign bus.illegal    = illegal_q;
  assign mtvec_out      = {mtvec_q, 2'b00};
  assign mepc_out       = {mepc_q, 2'b00};
  assign global_ie      = mstatus_mie_q;

endmodule
